ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter DWIDTH, default 18: memory word and stream data width in bits.
REQ-002 Parameter AWIDTH, default 10: memory address width in bits.
REQ-003 Parameter DEPTH, default 2**AWIDTH: number of addressable memory words; addresses wrap modulo DEPTH.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port start  input  1: one-cycle request to begin a burst read; sampled only in IDLE.
REQ-007 Port base_addr  input  AWIDTH: first word address of the burst; sampled with start.
REQ-008 Port count  input  AWIDTH+1: number of words in the burst, 0..DEPTH; sampled with start.
REQ-009 Port busy  output  1: high whenever the state is not IDLE.
REQ-010 Port done  output  1: one-cycle pulse at the end of a burst.
REQ-011 Port mem_en  output  1: memory port enable (read stage).
REQ-012 Port mem_enq  output  1: memory output-register enable.
REQ-013 Port mem_we  output  1: memory write enable; constant 0.
REQ-014 Port mem_addr  output  AWIDTH: memory address.
REQ-015 Port mem_wdata  output  DWIDTH: memory write data; constant 0.
REQ-016 Port mem_rdq  input  DWIDTH: registered memory read data (two-stage read: mem_en loads stage 1, mem_enq loads stage 2 from stage 1).
REQ-017 Port m_tdata  output  DWIDTH: stream data; equals mem_rdq.
REQ-018 Port m_tvalid  output  1: stream valid.
REQ-019 Port m_tready  input  1: stream ready from the sink.
REQ-020 Port m_tlast  output  1: high on the final beat of a burst.

Function
REQ-021 States IDLE, RUN (addresses still to issue), DRAIN (all issued, pipeline not empty).
REQ-022 IDLE + start + count>0 -> RUN; addr register <- base_addr, remaining <- count.
REQ-023 IDLE + start + count=0 -> stay IDLE; done pulses in the next cycle; no beats.
REQ-024 start while busy is ignored; base_addr/count are not re-sampled.
REQ-025 advance = !m_tvalid || m_tready (combinational).
REQ-026 mem_en = mem_enq = advance && busy; both low in IDLE and during stalls, so the memory pipeline holds its contents.
REQ-027 Issue occurs when mem_en=1 in RUN: mem_addr = addr register; then addr increments (DEPTH-1 wraps to 0) and remaining decrements.
REQ-028 Valid bits v1 (stage 1) and v2 (stage 2) track the memory pipeline: on advance, v1 <- issue, v2 <- v1; last flags l1/l2 travel alongside (set when remaining=1 at issue).
REQ-029 m_tvalid = v2, m_tlast = v2 && l2, m_tdata = mem_rdq; a beat transfers when m_tvalid && m_tready.
REQ-030 m_tvalid, once high, stays high with stable m_tdata/m_tlast until accepted.
REQ-031 Latency: start sampled at edge E0 -> first read issued in cycle after E0 -> m_tvalid high after E2 if m_tready stayed high.
REQ-032 Throughput: one beat per cycle while m_tready=1; no bubbles within a burst.
REQ-033 RUN -> DRAIN on the issue with remaining=1; DRAIN -> IDLE on the transfer of the tlast beat; done pulses the cycle after that transfer.
REQ-034 Exactly count beats per burst, addresses base_addr+i mod DEPTH, i=0..count-1; count=DEPTH reads every word once.
REQ-035 A new start is accepted in the cycle done is high (state is IDLE).

Reset
REQ-036 rst=1 at a rising edge: state IDLE, v1=v2=0, l1=l2=0, addr=0, remaining=0; outputs busy=0, done=0, m_tvalid=0, m_tlast=0, mem_en=mem_enq=0, mem_addr=0.
REQ-037 Reset mid-burst abandons the burst without a done pulse; no beat is presented after reset until a new start.

Verification
REQ-038 Memory model preloaded mem[i]=i; start base=5 count=4, m_tready=1 -> m_tvalid high after E2, data 5,6,7,8 on consecutive cycles, tlast on 8, done one cycle later.
REQ-039 DEPTH=1024, base=1022 count=4 -> data 1022,1023,0,1 with tlast on 1.
REQ-040 base=0 count=6, m_tready toggled 1,0,0,1,0,1,... -> data 0..5 exactly once in order, m_tdata stable while stalled, mem_en=mem_enq=0 in stall cycles.
REQ-041 start count=0 -> done pulses next cycle, m_tvalid never asserted, busy stays 0.
REQ-042 rst asserted after 2 of 8 beats, then start base=100 count=2 -> no stale beats, output 100,101 with tlast on 101, one done.
REQ-043 start pulsed again mid-burst with different base/count -> ignored; original burst completes unchanged; mem_we=0 throughout all tests.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Burst reader: issues sequential addresses to a two-stage registered RAM
// and presents the returned words as a valid/ready stream with tlast.
module ram_stream_reader #(
   parameter int DWIDTH = 18,
   parameter int AWIDTH = 10,
   parameter int DEPTH  = 2**AWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [AWIDTH:0]   count,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic              mem_enq,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdq,
   output logic [DWIDTH-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [AWIDTH-1:0] ADDR_MAX = AWIDTH'(DEPTH - 1);
   localparam logic [AWIDTH:0]   REM_ONE  = (AWIDTH+1)'(1);

   state_t              state_q;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic [AWIDTH:0]     remaining_q, remaining_d;
   logic                v1_q, v2_q, l1_q, l2_q;
   logic                done_q;
   logic                advance;
   logic                issue;
   logic                last_issue;

   // Pipeline advance, memory enables and issue qualification
   always_comb begin
      advance    = !v2_q || m_tready;
      busy       = (state_q != IDLE);
      mem_en     = advance && busy;
      mem_enq    = mem_en;
      issue      = mem_en && (state_q == RUN);
      last_issue = issue && (remaining_q == REM_ONE);
   end

   // Next address (wraps at DEPTH-1) and remaining-word count
   always_comb begin
      addr_d      = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
   end

   // Control FSM plus valid/last tracking of the two memory stages
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         l1_q        <= 1'b0;
         l2_q        <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Valid/last bits move only when the memory stages load, so they
         // stay aligned with the data held in the RAM output registers.
         if (mem_en) begin
            v1_q <= issue;
            l1_q <= last_issue;
            v2_q <= v1_q;
            l2_q <= l1_q;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (count != '0) begin
                     state_q     <= RUN;
                     addr_q      <= base_addr;
                     remaining_q <= count;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  addr_q      <= addr_d;
                  remaining_q <= remaining_d;
                  if (last_issue) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (v2_q && l2_q && m_tready) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output mapping
   always_comb begin
      done      = done_q;
      mem_we    = 1'b0;
      mem_wdata = '0;
      mem_addr  = addr_q;
      m_tdata   = mem_rdq;
      m_tvalid  = v2_q;
      m_tlast   = v2_q && l2_q;
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: two-stage RAM model preloaded
// with mem[i]=i, scoreboard of expected beats, stall/hold and done checks.
module tb_ram_stream_reader;

   localparam int DW = 18;
   localparam int AW = 10;
   localparam int DP = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic          busy, done;
   logic          mem_en, mem_enq, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdq;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid, m_tready, m_tlast;

   ram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .mem_en(mem_en), .mem_enq(mem_enq), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdq(mem_rdq),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
   );

   always #5 clk = ~clk;

   // Two-stage registered RAM model
   logic [DW-1:0] mem [DP];
   logic [DW-1:0] s1, s2;
   initial begin
      for (int i = 0; i < DP; i++) mem[i] = DW'(i);
      s1 = '0;
      s2 = '0;
   end
   always @(posedge clk) begin
      if (mem_en)  s1 <= mem[mem_addr];
      if (mem_enq) s2 <= s1;
   end
   assign mem_rdq = s2;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   // Scoreboard: {last, data}
   logic [DW:0] sb [$];
   int          done_cnt  = 0;
   int          beats     = 0;
   bit          done_arm  = 0;
   bit          stalled   = 0;
   logic [DW-1:0] hold_data;
   logic          hold_last;

   // Output monitor on the falling edge
   always @(negedge clk) begin
      bit          exp_done;
      logic [DW:0] e;
      exp_done = done_arm;
      done_arm = 0;
      if (done) done_cnt++;
      if (done || exp_done) check_eq("done_pulse", 32'(done), 32'(exp_done));
      if (rst) begin
         stalled = 0;
      end else begin
         if (stalled) begin
            check_eq("hold_valid", 32'(m_tvalid), 1);
            check_eq("hold_data", 32'(m_tdata), 32'(hold_data));
            check_eq("hold_last", 32'(m_tlast), 32'(hold_last));
         end
         if (m_tvalid && m_tready) begin
            stalled = 0;
            if (sb.size() == 0) begin
               check_eq("extra_beat", 32'(m_tvalid), 0);
            end else begin
               e = sb.pop_front();
               check_eq("beat_data", 32'(m_tdata), 32'(e[DW-1:0]));
               check_eq("beat_last", 32'(m_tlast), 32'(e[DW]));
               check_eq("mem_we", 32'(mem_we), 0);
            end
            if (m_tlast) done_arm = 1;
            beats++;
         end else if (m_tvalid) begin
            stalled   = 1;
            hold_data = m_tdata;
            hold_last = m_tlast;
            check_eq("stall_mem_en", 32'({mem_en, mem_enq}), 0);
         end else begin
            stalled = 0;
         end
      end
   end

   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_start(input int b, input int c, input bit push);
      start     = 1'b1;
      base_addr = AW'(b);
      count     = (AW+1)'(c);
      if (push)
         for (int i = 0; i < c; i++)
            sb.push_back({(i == c - 1), DW'((b + i) % DP)});
      tick();
      start = 1'b0;
   endtask

   // Runs with a ready pattern until done is high (we stop inside the done cycle)
   task automatic run_until_done(input int mode, input int budget);
      int n = 0;
      int pidx = 0;
      while (!done && n < budget) begin
         tick();
         n++;
         case (mode)
            0:       m_tready = 1'b1;
            1:       begin m_tready = pat[pidx % 6]; pidx++; end
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
      check_eq("done_reached", 32'(done), 1);
      check_eq("sb_empty", 32'(sb.size()), 0);
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_tvalid", 32'(m_tvalid), 0);
      check_eq("rst_tlast", 32'(m_tlast), 0);
      check_eq("rst_mem_en", 32'({mem_en, mem_enq}), 0);
      check_eq("rst_mem_addr", 32'(mem_addr), 0);
      check_eq("rst_wdata_we", 32'({mem_wdata, mem_we}), 0);
   endtask

   initial begin
      int d0;
      int b0;
      int n;
      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_tready = 1'b1;
      repeat (3) @(posedge clk);
      check_reset_state();
      @(posedge clk); #1 rst = 1'b0;
      tick();

      // Burst 5..8 with latency and back-to-back beats
      issue_start(5, 4, 1);
      @(negedge clk);
      check_eq("lat_busy", 32'(busy), 1);
      check_eq("lat_v_e0", 32'(m_tvalid), 0);
      @(negedge clk);
      check_eq("lat_v_e1", 32'(m_tvalid), 0);
      @(negedge clk);
      check_eq("lat_v_e2", 32'(m_tvalid), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("no_bubble", 32'(m_tvalid), 1);
      end
      run_until_done(0, 20);

      // Started in the done cycle: wrap 1022,1023,0,1
      issue_start(1022, 4, 1);
      @(negedge clk);
      check_eq("restart_busy", 32'(busy), 1);
      run_until_done(0, 20);

      // Stall pattern
      tick();
      issue_start(0, 6, 1);
      run_until_done(1, 60);
      m_tready = 1'b1;

      // Zero-length burst
      tick();
      d0 = done_cnt;
      issue_start(0, 0, 0);
      done_arm = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("zero_busy", 32'(busy), 0);
         check_eq("zero_tvalid", 32'(m_tvalid), 0);
         check_eq("zero_mem_en", 32'(mem_en), 0);
      end
      check_eq("zero_done_cnt", 32'(done_cnt - d0), 1);

      // Reset mid-burst after two beats
      tick();
      d0 = done_cnt;
      b0 = beats;
      issue_start(200, 8, 1);
      n = 0;
      while (beats < b0 + 2 && n < 20) begin tick(); n++; end
      check_eq("two_beats", 32'(beats - b0), 2);
      rst = 1'b1;
      m_tready = 1'b0;
      tick();
      sb.delete();
      check_reset_state();
      @(posedge clk); #1;
      rst = 1'b0;
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("no_stale", 32'(m_tvalid), 0);
      end
      check_eq("no_done_rst", 32'(done_cnt - d0), 0);
      tick();
      issue_start(100, 2, 1);
      run_until_done(0, 20);
      tick();
      check_eq("one_done", 32'(done_cnt - d0), 1);

      // Start pulsed mid-burst is ignored
      d0 = done_cnt;
      issue_start(300, 5, 1);
      tick();
      issue_start(10, 3, 0);
      run_until_done(0, 30);
      repeat (5) tick();
      check_eq("ignored_start", 32'(done_cnt - d0), 1);
      check_eq("idle_after", 32'(busy), 0);

      // Full-depth burst with random ready
      issue_start(700, DP, 1);
      run_until_done(2, 6000);
      m_tready = 1'b1;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
